// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the DLX pipeline latches and PC: load-use, branch flush, memory wait, drain/halt, watchdog.
// Optional stall-cycle performance counter is built when PIPE_STALL_COUNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rw,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        halt_req,
    output logic        en_pc,
    output logic        en_if_id,
    output logic        en_id_ex,
    output logic        en_ex_mem,
    output logic        en_mem_wb,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic [1:0]  state,
    output logic        halted,
    output logic        mem_fault,
    output logic [31:0] stall_cycles
);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;
    localparam logic [1:0] FAULT  = 2'd3;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);
    localparam bit         WDOG_EN    = (MEM_TIMEOUT != 0);

    logic [1:0] state_q, state_d;
    logic [3:0] drain_cnt_q, drain_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mstall;
    logic       luse;

    assign mstall = mem_req & ~mem_ready;
    assign luse   = ex_mem_read & (ex_rw != 5'd0) &
                    ((ex_rw == id_rs) | (id_uses_rt & (ex_rw == id_rt)));

    always_comb begin
        en_pc       = 1'b1;
        en_if_id    = 1'b1;
        en_id_ex    = 1'b1;
        en_ex_mem   = 1'b1;
        en_mem_wb   = 1'b1;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (state_q == HALTED || state_q == FAULT || mstall) begin
            en_pc     = 1'b0;
            en_if_id  = 1'b0;
            en_id_ex  = 1'b0;
            en_ex_mem = 1'b0;
            en_mem_wb = 1'b0;
        end else if (state_q == DRAIN || halt_req || luse) begin
            // Front end holds while a bubble enters EX; a taken branch waits for the next cycle.
            en_pc       = 1'b0;
            en_if_id    = 1'b0;
            flush_id_ex = 1'b1;
        end else if (branch_taken) begin
            flush_if_id = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        if (mstall)
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
        else
            wait_cnt_d = 8'd0;

        if (WDOG_EN && mstall && (wait_cnt_q == WAIT_LAST) && (state_q != HALTED)) begin
            state_d = FAULT;
        end else begin
            case (state_q)
                RUN: begin
                    if (halt_req && !mstall) begin
                        if (DRAIN_CYCLES == 1) begin
                            state_d = HALTED;
                        end else begin
                            state_d     = DRAIN;
                            drain_cnt_d = DRAIN_LOAD;
                        end
                    end
                end
                DRAIN: begin
                    // The accepting RUN cycle is the first frozen cycle, so halt once the count runs out.
                    if (!mstall) begin
                        if (drain_cnt_q <= 4'd1) begin
                            state_d     = HALTED;
                            drain_cnt_d = 4'd0;
                        end else begin
                            drain_cnt_d = drain_cnt_q - 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            drain_cnt_q <= 4'd0;
            wait_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign state     = state_q;
    assign halted    = (state_q == HALTED);
    assign mem_fault = (state_q == FAULT);

`ifdef PIPE_STALL_COUNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            stall_q <= 32'd0;
        else if ((state_q == RUN || state_q == DRAIN) && !en_pc && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios then random traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int DC = 3;
    localparam int MT = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [4:0]  id_rs, id_rt, ex_rw;
    logic        id_uses_rt, ex_mem_read, branch_taken, mem_req, mem_ready, halt_req;
    logic        en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic        flush_if_id, flush_id_ex, halted, mem_fault;
    logic [1:0]  state;
    logic [31:0] stall_cycles;

    int n_chk  = 0;
    int n_fail = 0;

    // model: 0 run, 1 drain, 2 halted, 3 fault
    int          m_state;
    int          m_left;
    int          m_wait;
    longint      m_stall;
    logic [4:0]  e_en;
    logic [1:0]  e_fl;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(DC), .MEM_TIMEOUT(MT)) dut (
        .clock(clock), .reset_n(reset_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rw(ex_rw), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
        .en_pc(en_pc), .en_if_id(en_if_id), .en_id_ex(en_id_ex),
        .en_ex_mem(en_ex_mem), .en_mem_wb(en_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .state(state), .halted(halted), .mem_fault(mem_fault),
        .stall_cycles(stall_cycles)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_mstall();
        return mem_req && !mem_ready;
    endfunction

    function automatic bit m_luse();
        if (!ex_mem_read || ex_rw == 5'd0) return 1'b0;
        return (ex_rw == id_rs) || (id_uses_rt && ex_rw == id_rt);
    endfunction

    task automatic model_outs();
        if (m_state >= 2 || m_mstall()) begin
            e_en = 5'b00000; e_fl = 2'b00;
        end else if (m_state == 1 || halt_req || m_luse()) begin
            e_en = 5'b00111; e_fl = 2'b01;
        end else if (branch_taken) begin
            e_en = 5'b11111; e_fl = 2'b10;
        end else begin
            e_en = 5'b11111; e_fl = 2'b00;
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_left = 0; m_wait = 0; m_stall = 0;
    endtask

    task automatic model_step();
        bit ms;
        model_outs();
        ms = m_mstall();
        if (m_state <= 1 && e_en[4] == 1'b0 && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (m_state != 2 && MT != 0 && ms && m_wait + 1 == MT) begin
            m_state = 3;
        end else if (m_state == 0) begin
            if (halt_req && !ms) begin
                m_left  = DC - 1;
                m_state = (m_left == 0) ? 2 : 1;
            end
        end else if (m_state == 1) begin
            if (!ms) begin
                m_left--;
                if (m_left == 0) m_state = 2;
            end
        end
        m_wait = ms ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e_sc;
        model_outs();
`ifdef PIPE_STALL_COUNT_EN
        e_sc = m_stall[31:0];
`else
        e_sc = 32'h0;
`endif
        check({tag, ".en"},    {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb}, e_en);
        check({tag, ".flush"}, {flush_if_id, flush_id_ex}, e_fl);
        check({tag, ".state"}, state, m_state[1:0]);
        check({tag, ".halt_fault"}, {halted, mem_fault}, {m_state == 2, m_state == 3});
        check({tag, ".stall_cycles"}, stall_cycles, e_sc);
    endtask

    // Called at posedge+1: apply inputs, check mid-cycle, advance one clock.
    task automatic drive(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urt, input logic lr, input logic [4:0] rw,
                         input logic br, input logic mr, input logic mrdy, input logic hr);
        id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = lr; ex_rw = rw;
        branch_taken = br; mem_req = mr; mem_ready = mrdy; halt_req = hr;
        #3;
        check_all(tag);
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle(input string tag);
        drive(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_mem_read = 0; ex_rw = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 0; halt_req = 0;
        reset_n = 1'b0;
        #3;
        model_reset();
        check_all(tag);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        model_step();
        #1;
    endtask

    initial begin
        int burst;
        int dead;
        logic hr;
        reset_n = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
        do_reset("reset");
        idle("idle");

        drive("luse_rs", 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("luse_r0", 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("luse_rt", 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("rt_unused", 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        drive("luse_br", 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        drive("br_after", 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);

        do_reset("reset2");
        for (int i = 0; i < 3; i++)
            drive("mwait", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive("mdone", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle("mpost");

        for (int i = 0; i < 6; i++)
            drive("wdog", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle("fault_hold");
        do_reset("reset3");

        drive("halt_acc", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle("drain1");
        drive("drain_stall", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle("drain2");
        idle("halted");
        idle("halted_hold");
        do_reset("reset4");

        drive("halt_acc2", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle("drain_mid");
        do_reset("reset_mid_drain");
        for (int i = 0; i < 4; i++) idle("post_reset");

        burst = 0;
        dead  = 0;
        hr    = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic mr, mrdy;
            if (m_state >= 2) begin
                dead++;
                if (dead > 3) begin
                    do_reset("rnd_reset");
                    dead = 0;
                    hr   = 1'b0;
                    continue;
                end
            end
            if (!hr && $urandom_range(0, 39) == 0) hr = 1'b1;
            if (m_state == 2) hr = 1'b0;
            if (burst == 0 && $urandom_range(0, 99) == 0) burst = $urandom_range(2, 6);
            if (burst > 0) begin
                mr = 1'b1; mrdy = 1'b0; burst--;
            end else begin
                mr   = ($urandom_range(0, 2) == 0);
                mrdy = ($urandom_range(0, 3) != 0);
            end
            drive("rnd", 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                  mr, mrdy, hr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
